// File: rtl/bram_port_client_pkg.sv
// Shared defaults and request record for the BRAM port client.
package bram_port_client_pkg;

   localparam int BRAM_ADDR_WIDTH = 10;
   localparam int BRAM_DATA_WIDTH = 36;

   typedef struct packed {
      logic                       write;
      logic [BRAM_ADDR_WIDTH-1:0] addr;
      logic [BRAM_DATA_WIDTH-1:0] data;
   } bram_req_t;

endpackage

// File: rtl/bram_port_client_if.sv
// Request/response streams plus BRAM port strobes for one client instance.
interface bram_port_client_if #(
   parameter int ADDR_WIDTH = bram_port_client_pkg::BRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = bram_port_client_pkg::BRAM_DATA_WIDTH
) ();
   logic                  io_req_valid;
   logic                  io_req_ready;
   logic                  io_req_bits_write;
   logic [ADDR_WIDTH-1:0] io_req_bits_addr;
   logic [DATA_WIDTH-1:0] io_req_bits_data;
   logic                  io_resp_valid;
   logic                  io_resp_ready;
   logic [DATA_WIDTH-1:0] io_resp_bits_data;
   logic                  io_port_en;
   logic                  io_port_writeEn;
   logic [ADDR_WIDTH-1:0] io_port_addr;
   logic [DATA_WIDTH-1:0] io_port_dataIn;
   logic [DATA_WIDTH-1:0] io_port_dataOut;

   // slave: the client block; master: requester plus the BRAM it drives
   modport slave (
      input  io_req_valid, io_req_bits_write, io_req_bits_addr, io_req_bits_data,
      input  io_resp_ready, io_port_dataOut,
      output io_req_ready, io_resp_valid, io_resp_bits_data,
      output io_port_en, io_port_writeEn, io_port_addr, io_port_dataIn
   );

   modport master (
      output io_req_valid, io_req_bits_write, io_req_bits_addr, io_req_bits_data,
      output io_resp_ready, io_port_dataOut,
      input  io_req_ready, io_resp_valid, io_resp_bits_data,
      input  io_port_en, io_port_writeEn, io_port_addr, io_port_dataIn
   );
endinterface

// File: rtl/bram_resp_queue.sv
// Circular response FIFO with occupancy count; push and pop may share a cycle.
module bram_resp_queue
   import bram_port_client_pkg::*;
#(
   parameter int DATA_WIDTH = BRAM_DATA_WIDTH,
   parameter int DEPTH      = 3,
   localparam int CW        = $clog2(DEPTH + 1),
   localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_head,
   output logic [CW-1:0]         o_count,
   output logic                  o_full,
   output logic                  o_empty
);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  w_push, w_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; pointers alone define validity.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/bram_port_client.sv
// Turns a ready/valid read/write stream into BRAM port strobes and queues read data.
module bram_port_client
   import bram_port_client_pkg::*;
#(
   parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = BRAM_DATA_WIDTH,
   parameter int RESP_DEPTH = 3
) (
   input  logic              clock,
   input  logic              reset,
   bram_port_client_if.slave bus
);
   localparam int CW = $clog2(RESP_DEPTH + 1);

   logic                  r_inflight;
   logic                  w_fire, w_pop, w_full, w_empty;
   logic [CW-1:0]         w_count;
   logic [CW:0]           w_occ;
   logic [DATA_WIDTH-1:0] w_head;

   // Credit: a read in flight already owns a queue slot.
   assign w_occ = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};

   assign bus.io_req_ready    = !reset && (w_occ < (CW+1)'(RESP_DEPTH));
   assign w_fire              = bus.io_req_valid && bus.io_req_ready;
   assign bus.io_port_en      = w_fire;
   assign bus.io_port_writeEn = w_fire && bus.io_req_bits_write;
   assign bus.io_port_addr    = bus.io_req_bits_addr;
   assign bus.io_port_dataIn  = bus.io_req_bits_data;

   assign bus.io_resp_valid     = !reset && !w_empty;
   assign bus.io_resp_bits_data = w_head;
   assign w_pop                 = bus.io_resp_valid && bus.io_resp_ready;

   always_ff @(posedge clock) begin
      if (reset) r_inflight <= 1'b0;
      else       r_inflight <= w_fire && !bus.io_req_bits_write;
   end

   bram_resp_queue #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RESP_DEPTH)
   ) u_queue (
      .clock       (clock),
      .reset       (reset),
      .i_push      (r_inflight),
      .i_push_data (bus.io_port_dataOut),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (w_count),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   a_no_push_on_full: assert property (@(posedge clock) disable iff (reset)
      !(r_inflight && w_full));

endmodule

// File: tb/tb_bram_port_client.sv
// Bench for bram_port_client: BRAM model, reference memory + expected-response queue.
module tb_bram_port_client;
   import bram_port_client_pkg::*;

   localparam int AW    = BRAM_ADDR_WIDTH;
   localparam int DW    = BRAM_DATA_WIDTH;
   localparam int DEPTH = 3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clock = ~clock;

   bram_port_client_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   bram_port_client #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RESP_DEPTH (DEPTH)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   function automatic logic [DW-1:0] init_word(input int i);
      return (DW'(i) * DW'(36'h09E3779B1)) ^ DW'(36'hA5A5A5A5A);
   endfunction

   // Environment BRAM: 1-cycle registered read.
   logic [DW-1:0] bram [2**AW];
   initial for (int i = 0; i < 2**AW; i++) bram[i] = init_word(i);
   always @(posedge clock) begin
      if (bus.io_port_en) begin
         if (bus.io_port_writeEn) bram[bus.io_port_addr] <= bus.io_port_dataIn;
         else                     bus.io_port_dataOut <= bram[bus.io_port_addr];
      end
   end

   // Reference: memory contents as seen in request order, and the responses still owed.
   logic [DW-1:0] ref_mem [2**AW];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] m_exp;
   initial for (int i = 0; i < 2**AW; i++) ref_mem[i] = init_word(i);

   always @(negedge clock) begin
      if (reset) exp_q.delete();
      else begin
         if (bus.io_resp_valid && exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL resp_unexpected: resp_valid=1 with data %h, required no response", bus.io_resp_bits_data);
         end else if (bus.io_resp_valid && bus.io_resp_ready) begin
            m_exp = exp_q.pop_front();
            n_vec++;
            if (bus.io_resp_bits_data !== m_exp) begin
               n_err++;
               $display("FAIL resp_data: got %h, required %h", bus.io_resp_bits_data, m_exp);
            end
         end
         if (bus.io_req_valid && bus.io_req_ready) begin
            if (bus.io_req_bits_write) ref_mem[bus.io_req_bits_addr] = bus.io_req_bits_data;
            else                       exp_q.push_back(ref_mem[bus.io_req_bits_addr]);
         end
      end
   end

   task automatic step();
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.io_req_valid = 1'b1; bus.io_req_bits_write = 1'b1;
      bus.io_req_bits_addr = AW'(1); bus.io_req_bits_data = '0;
      repeat (3) begin
         @(negedge clock); n_vec++;
         if (bus.io_req_ready !== 1'b0 || bus.io_port_en !== 1'b0 ||
             bus.io_port_writeEn !== 1'b0 || bus.io_resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%b en=%b we=%b rv=%b, required all 0",
                     bus.io_req_ready, bus.io_port_en, bus.io_port_writeEn, bus.io_resp_valid);
         end
      end
      step(); reset = 1'b0; bus.io_req_valid = 1'b0;
      @(negedge clock); n_vec++;
      if (bus.io_req_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_release_ready: got %b, required 1", bus.io_req_ready);
      end
   endtask

   task automatic test_write_read();
      int we_pulses = 0;
      bus.io_resp_ready = 1'b1;
      step();
      bus.io_req_valid = 1'b1; bus.io_req_bits_write = 1'b1;
      bus.io_req_bits_addr = AW'(5); bus.io_req_bits_data = 36'h123456789;
      @(negedge clock); n_vec++;
      if (bus.io_port_writeEn === 1'b1) we_pulses++;
      if (bus.io_port_en !== 1'b1 || bus.io_port_addr !== AW'(5) || bus.io_port_dataIn !== 36'h123456789) begin
         n_err++; $display("FAIL wr_strobe: en=%b addr=%0d din=%h, required 1/5/123456789",
                           bus.io_port_en, bus.io_port_addr, bus.io_port_dataIn);
      end
      step(); bus.io_req_bits_write = 1'b0;
      @(negedge clock); n_vec++;
      if (bus.io_port_writeEn === 1'b1) we_pulses++;
      if (bus.io_port_en !== 1'b1) begin
         n_err++; $display("FAIL rd_strobe: en=%b, required 1", bus.io_port_en);
      end
      step(); bus.io_req_valid = 1'b0;
      @(negedge clock); n_vec++;
      if (bus.io_port_writeEn === 1'b1) we_pulses++;
      if (bus.io_resp_valid !== 1'b0) begin
         n_err++; $display("FAIL rd_lat_t1: resp_valid=%b, required 0", bus.io_resp_valid);
      end
      step();
      @(negedge clock); n_vec++;
      if (bus.io_resp_valid !== 1'b1 || bus.io_resp_bits_data !== 36'h123456789) begin
         n_err++; $display("FAIL rd_lat_t2: valid=%b data=%h, required 1/123456789",
                           bus.io_resp_valid, bus.io_resp_bits_data);
      end
      n_vec++;
      if (we_pulses != 1) begin
         n_err++; $display("FAIL we_pulses: got %0d, required 1", we_pulses);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] got [$];
      bus.io_resp_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         step();
         bus.io_req_valid = (c < 8); bus.io_req_bits_write = 1'b0;
         bus.io_req_bits_addr = AW'(c % 8);
         @(negedge clock);
         if (c < 8) begin
            n_vec++;
            if (bus.io_req_ready !== 1'b1) begin
               n_err++; $display("FAIL b2b_ready: cycle %0d ready=%b, required 1", c, bus.io_req_ready);
            end
         end
         if (c >= 2 && c < 10) begin
            n_vec++;
            if (bus.io_resp_valid !== 1'b1) begin
               n_err++; $display("FAIL b2b_gap: cycle %0d resp_valid=%b, required 1", c, bus.io_resp_valid);
            end
         end
         if (bus.io_resp_valid === 1'b1) got.push_back(bus.io_resp_bits_data);
      end
      n_vec++;
      if (got.size() != 8) begin
         n_err++; $display("FAIL b2b_count: got %0d responses, required 8", got.size());
      end
      for (int i = 0; i < got.size() && i < 8; i++) begin
         n_vec++;
         if (got[i] !== ref_mem[i]) begin
            n_err++; $display("FAIL b2b_order: idx %0d got %h, required %h", i, got[i], ref_mem[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      int k = 0;
      bus.io_resp_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         bus.io_req_valid = 1'b1; bus.io_req_bits_write = 1'b0;
         bus.io_req_bits_addr = AW'(20 + c);
         @(negedge clock);
         if (bus.io_req_ready === 1'b1) acc++;
      end
      n_vec++;
      if (acc != DEPTH) begin
         n_err++; $display("FAIL bp_accepts: got %0d, required %0d", acc, DEPTH);
      end
      n_vec++;
      if (bus.io_req_ready !== 1'b0) begin
         n_err++; $display("FAIL bp_ready_low: got %b, required 0", bus.io_req_ready);
      end
      step(); bus.io_resp_ready = 1'b1;
      @(negedge clock); n_vec++;
      if (bus.io_resp_valid !== 1'b1 || bus.io_req_ready !== 1'b0) begin
         n_err++; $display("FAIL bp_pop: resp_valid=%b req_ready=%b, required 1/0",
                           bus.io_resp_valid, bus.io_req_ready);
      end
      step(); bus.io_resp_ready = 1'b0;
      @(negedge clock); n_vec++;
      if (bus.io_req_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_reaccept: req_ready=%b, required 1", bus.io_req_ready);
      end
      step();
      @(negedge clock); n_vec++;
      if (bus.io_req_ready !== 1'b0) begin
         n_err++; $display("FAIL bp_refill: req_ready=%b, required 0", bus.io_req_ready);
      end
      step(); bus.io_req_valid = 1'b0; bus.io_resp_ready = 1'b1;
      while (exp_q.size() != 0 && k < 20) begin @(negedge clock); k++; end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL bp_drain: %0d responses outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_interleave();
      logic [DW-1:0] got [$];
      logic [63:0]   t;
      logic [DW-1:0] a, b;
      t = {$urandom(), $urandom()}; a = t[DW-1:0];
      t = {$urandom(), $urandom()}; b = t[DW-1:0];
      bus.io_resp_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         bus.io_req_valid = (c < 4); bus.io_req_bits_write = (c % 2 == 0);
         bus.io_req_bits_addr = AW'(3); bus.io_req_bits_data = (c < 2) ? a : b;
         @(negedge clock);
         if (c < 4) begin
            n_vec++;
            if (bus.io_req_ready !== 1'b1) begin
               n_err++; $display("FAIL il_ready: step %0d ready=%b, required 1", c, bus.io_req_ready);
            end
         end
         if (bus.io_resp_valid === 1'b1) got.push_back(bus.io_resp_bits_data);
      end
      n_vec++;
      if (got.size() != 2) begin
         n_err++; $display("FAIL il_count: got %0d, required 2", got.size());
      end else begin
         n_vec++;
         if (got[0] !== a || got[1] !== b) begin
            n_err++; $display("FAIL il_order: got %h,%h required %h,%h", got[0], got[1], a, b);
         end
      end
   endtask

   task automatic test_reset_drop();
      bus.io_resp_ready = 1'b1;
      step();
      bus.io_req_valid = 1'b1; bus.io_req_bits_write = 1'b0; bus.io_req_bits_addr = AW'(7);
      @(negedge clock); n_vec++;
      if (bus.io_port_en !== 1'b1) begin
         n_err++; $display("FAIL rd_fire_pre_reset: en=%b, required 1", bus.io_port_en);
      end
      step(); reset = 1'b1;
      repeat (2) begin
         @(negedge clock); n_vec++;
         if (bus.io_resp_valid !== 1'b0 || bus.io_port_en !== 1'b0 || bus.io_req_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_mid: rv=%b en=%b ready=%b, required 0/0/0",
                              bus.io_resp_valid, bus.io_port_en, bus.io_req_ready);
         end
         step();
      end
      reset = 1'b0; bus.io_req_valid = 1'b0;
      @(negedge clock); n_vec++;
      if (bus.io_req_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_drop_ready: got %b, required 1", bus.io_req_ready);
      end
      repeat (5) begin
         step();
         @(negedge clock); n_vec++;
         if (bus.io_resp_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_drop_resp: resp_valid=%b, required 0", bus.io_resp_valid);
         end
      end
   endtask

   task automatic test_stress();
      bram_req_t   r;
      logic [63:0] t;
      logic        pending = 1'b0;
      int          k = 0;
      for (int c = 0; c < 600; c++) begin
         step();
         if (!pending) begin
            t      = {$urandom(), $urandom()};
            r.write = $urandom_range(0, 2) == 0;
            r.addr  = AW'($urandom_range(0, 15));
            r.data  = t[DW-1:0];
            pending = $urandom_range(0, 3) != 0;
         end
         bus.io_req_valid = pending; bus.io_req_bits_write = r.write;
         bus.io_req_bits_addr = r.addr; bus.io_req_bits_data = r.data;
         bus.io_resp_ready = $urandom_range(0, 3) != 0;
         @(negedge clock); n_vec++;
         if (bus.io_port_en !== (pending && bus.io_req_ready) ||
             bus.io_port_writeEn !== (pending && bus.io_req_ready && r.write)) begin
            n_err++; $display("FAIL stress_strobe: cycle %0d en=%b we=%b, required %b/%b", c,
                              bus.io_port_en, bus.io_port_writeEn, pending && bus.io_req_ready,
                              pending && bus.io_req_ready && r.write);
         end
         if (pending && bus.io_req_ready) pending = 1'b0;
      end
      step(); bus.io_req_valid = 1'b0; bus.io_resp_ready = 1'b1;
      while (exp_q.size() != 0 && k < 20) begin @(negedge clock); k++; end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL stress_drain: %0d responses outstanding, required 0", exp_q.size());
      end
   endtask

   initial begin
      bus.io_req_valid = 1'b0; bus.io_req_bits_write = 1'b0;
      bus.io_req_bits_addr = '0; bus.io_req_bits_data = '0;
      bus.io_resp_ready = 1'b0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_backpressure();
      test_interleave();
      test_reset_drop();
      test_stress();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bram_port_client.md
# bram_port_client

Initiator for one port of a true-dual-port BRAM: converts an in-order ready/valid request stream (read or write) into the BRAM port's `en`/`writeEn`/`addr`/`dataIn` strobes, then returns read data on a ready/valid response stream. It absorbs the BRAM's fixed 1-cycle read latency and handles response backpressure with a credit-limited response queue. Typical placement is between a pipeline stage or DMA engine and portA/portB of the shared BRAM wrapper. One instance drives one port.

## Interface
- `ADDR_WIDTH`, 10, BRAM address width
- `DATA_WIDTH`, 36, BRAM data width
- `RESP_DEPTH`, 3, response queue entries (≥3 for full throughput)

Single clock domain; reset is synchronous, active-high.
- `clock`  in  1  clock
- `reset`  in  1  sync active-high reset
- `io_req_valid`  in  1  request present
- `io_req_ready`  out  1  request accepted when valid&ready
- `io_req_bits_write`  in  1  1 = write, 0 = read
- `io_req_bits_addr`  in  ADDR_WIDTH  word address
- `io_req_bits_data`  in  DATA_WIDTH  write data (ignored for reads)
- `io_resp_valid`  out  1  read data available
- `io_resp_ready`  in  1  consumer takes response
- `io_resp_bits_data`  out  DATA_WIDTH  read data
- `io_port_en`  out  1  BRAM port enable
- `io_port_writeEn`  out  1  BRAM port write enable
- `io_port_addr`  out  ADDR_WIDTH  BRAM address
- `io_port_dataIn`  out  DATA_WIDTH  BRAM write data
- `io_port_dataOut`  in  DATA_WIDTH  BRAM read data, valid 1 cycle after read enable

## Operation
- Outstanding count `occ = inflight + q_count`; `inflight` = 1 iff a read was issued in the previous cycle.
- `io_req_ready = !reset && occ < RESP_DEPTH`; independent of `io_req_valid`/`io_req_bits_*` and of `io_resp_ready`. Writes are throttled by the same condition (keeps in-order semantics simple).
- Request fire: `io_port_en = fire`, `io_port_writeEn = fire & write`, `io_port_addr/dataIn` = request bits (combinational pass-through; addr/data don't-care when `en`=0).
- Read fire sets `inflight` next cycle; write fire leaves it 0. Writes produce no response.
- When `inflight`=1, `io_port_dataOut` is pushed into the queue at end of that cycle. Queue is never full on push (credit guarantees it); push on full is an assertion failure.
- `io_resp_valid = q_count != 0`; head data on `io_resp_bits_data`; pop on valid&ready. Push and pop in the same cycle: count unchanged, order preserved.
- Ordering: responses in read-issue order. Read issued the cycle after a write to the same address returns the new data (BRAM sees them in order).
- Reset: clears `inflight`, queue pointers and count; any in-flight read is dropped, no response emitted. Queue storage not reset.

## Timing
- All outputs during/after reset: `io_req_ready`=0 while reset is high, then 1; `io_resp_valid`=0; `io_port_en`=0; `io_port_writeEn`=0.
- Read latency: fire at cycle T → BRAM data at T+1 → `io_resp_valid` at T+2 (if queue was empty).
- Throughput: with `RESP_DEPTH`=3 and `io_resp_ready` held high, one read accepted per cycle indefinitely.
- With `io_resp_ready`=0: exactly `RESP_DEPTH` reads accepted, then `io_req_ready` drops; rises the cycle after the first pop.

## Structure
- Shared package: `BRAM_ADDR_WIDTH`, `BRAM_DATA_WIDTH` defaults, request struct typedef (`write`, `addr`, `data`).
- One sub-module: `bram_resp_queue` — DATA_WIDTH × RESP_DEPTH circular FIFO, count, full/empty, simultaneous push/pop.
- Top holds only `inflight` flop, credit compare and port strobes.

## Test plan
- Write addr 5 = 0x123456789, then read addr 5 next cycle → `io_port_writeEn` pulses once; response 0x123456789 at T+2 of the read.
- Back-to-back reads addr 0..7 with `io_resp_ready`=1 → `io_req_ready` never drops; 8 responses in address order on consecutive cycles.
- `io_resp_ready`=0, 5 reads offered → exactly 3 accepted, `io_req_ready`=0; raise ready one cycle → 1 pop, 1 new accept next cycle.
- Interleaved W(3,A), R(3), W(3,B), R(3) → responses A then B.
- Reset asserted the cycle after a read fire → no response ever appears; `io_resp_valid`=0, `io_port_en`=0 during reset, `io_req_ready`=1 the cycle after reset deasserts.
- Random valid/ready stress vs. reference memory model → data match, no queue overflow assertion.
